// File: rtl/grayscale_pipe_if.sv
// Stream bundle for grayscale_pipe: RGB565 input beats with per-beat config,
// and packed 8-bit output beats. The DUT uses the slave side.
interface grayscale_pipe_if #(
  parameter int PIXELS = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [16*PIXELS-1:0]  in_data;
  logic                  mode;
  logic [7:0]            threshold;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*PIXELS-1:0]   out_data;

  modport master (
    output in_valid, in_data, mode, threshold, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, mode, threshold, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/grayscale_pipe.sv
// Two-stage RGB565 -> grayscale/threshold converter, PIXELS lanes per beat.
// Whole pipe advances on a single adv strobe; beat_count tallies output transfers.
module gp_lane #(
  parameter int WR = 54,
  parameter int WG = 182,
  parameter int WB = 19
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        adv,
  input  logic [15:0] px,
  input  logic        mode_s1,
  input  logic [7:0]  thr_s1,
  output logic [7:0]  pix_out
);
  localparam logic [7:0] WR8 = WR[7:0];
  localparam logic [7:0] WG8 = WG[7:0];
  localparam logic [7:0] WB8 = WB[7:0];

  logic [12:0] pr, pb;
  logic [13:0] pg;
  logic [7:0]  r_s1, b_s1;
  logic [8:0]  g_s1;
  logic [9:0]  sum;
  logic [7:0]  gray, res;

  // Full-width products so the floor divides are exact.
  assign pr = {8'd0, px[15:11]} * {5'd0, WR8};
  assign pg = {8'd0, px[10:5]}  * {6'd0, WG8};
  assign pb = {8'd0, px[4:0]}   * {5'd0, WB8};

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_s1 <= '0;
      g_s1 <= '0;
      b_s1 <= '0;
    end else if (adv) begin
      r_s1 <= 8'(pr >> 5);
      g_s1 <= 9'(pg >> 6);
      b_s1 <= 8'(pb >> 5);
    end
  end

  assign sum  = {2'b00, r_s1} + {1'b0, g_s1} + {2'b00, b_s1};
  assign gray = (sum > 10'd255) ? 8'hFF : sum[7:0];
  assign res  = mode_s1 ? ((gray >= thr_s1) ? 8'hFF : 8'h00) : gray;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset)  pix_out <= '0;
    else if (adv) pix_out <= res;
  end
endmodule

module grayscale_pipe #(
  parameter int PIXELS = 2,
  parameter int WR     = 54,
  parameter int WG     = 182,
  parameter int WB     = 19
) (
  input  logic               clock,
  input  logic               nReset,
  grayscale_pipe_if.slave    bus,
  input  logic               count_clear,
  output logic [31:0]        beat_count
);
  localparam int STAGES = 2;

  logic                    adv;
  logic [STAGES:1]         vld_pipe;
  logic                    mode_s1;
  logic [7:0]              thr_s1;
  logic [PIXELS-1:0][7:0]  out_px;

  assign adv           = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_data  = out_px;

  // Config rides alongside stage 1 so it stays paired with its beat.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      vld_pipe <= '0;
      mode_s1  <= 1'b0;
      thr_s1   <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
      mode_s1  <= bus.mode;
      thr_s1   <= bus.threshold;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset)                             beat_count <= '0;
    else if (count_clear)                    beat_count <= '0;
    else if (bus.out_valid && bus.out_ready) beat_count <= beat_count + 32'd1;
  end

  for (genvar i = 0; i < PIXELS; i++) begin : g_lane
    gp_lane #(.WR(WR), .WG(WG), .WB(WB)) u_lane (
      .clock   (clock),
      .nReset  (nReset),
      .adv     (adv),
      .px      (bus.in_data[16*i +: 16]),
      .mode_s1 (mode_s1),
      .thr_s1  (thr_s1),
      .pix_out (out_px[i])
    );
  end
endmodule

// File: tb/tb_grayscale_pipe.sv
// Directed bench for grayscale_pipe: latency, channel weights, threshold mode,
// backpressure, count clear, mid-stream reset and saturation (WG=255 build).
module tb_grayscale_pipe;
  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        count_clear = 1'b0;
  logic [31:0] beat_count, beat_count2;
  int          tests = 0, fails = 0;

  logic [31:0] bdata [8];
  logic        bmode [8];
  logic [7:0]  bthr  [8];
  logic [15:0] bexp  [8];

  always #5 clock = ~clock;

  grayscale_pipe_if #(.PIXELS(2)) u_if ();
  grayscale_pipe_if #(.PIXELS(2)) u_if2 ();

  grayscale_pipe #(.PIXELS(2)) dut (
    .clock(clock), .nReset(nReset), .bus(u_if),
    .count_clear(count_clear), .beat_count(beat_count)
  );

  grayscale_pipe #(.PIXELS(2), .WG(255)) dut_sat (
    .clock(clock), .nReset(nReset), .bus(u_if2),
    .count_clear(1'b0), .beat_count(beat_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_beat(input int k, input logic [31:0] d, input logic m,
                          input logic [7:0] t, input logic [15:0] e);
    bdata[k] = d; bmode[k] = m; bthr[k] = t; bexp[k] = e;
  endtask

  // Drives n beats from the tables, drops out_ready for cycles [st_lo, st_hi),
  // and checks every output transfer in order.
  task automatic run_stream(input int n, input int st_lo, input int st_hi, output int cycles);
    int ni = 0, no = 0, cyc = 0;
    logic [15:0] held = '0;
    bit stalled_prev = 0;
    while (no < n && cyc < 60) begin
      u_if.out_ready = !(cyc >= st_lo && cyc < st_hi);
      u_if.in_valid  = (ni < n);
      if (ni < n) begin
        u_if.in_data   = bdata[ni];
        u_if.mode      = bmode[ni];
        u_if.threshold = bthr[ni];
      end
      #1;
      if (u_if.out_valid && !u_if.out_ready) begin
        check("stall_in_ready", 32'(u_if.in_ready), 32'd0);
        if (stalled_prev) check("stall_hold", 32'(u_if.out_data), 32'(held));
        held = u_if.out_data;
        stalled_prev = 1;
      end else stalled_prev = 0;
      if (u_if.in_valid && u_if.in_ready) ni++;
      if (u_if.out_valid && u_if.out_ready) begin
        check($sformatf("beat%0d", no), 32'(u_if.out_data), 32'(bexp[no]));
        no++;
      end
      step();
      cyc++;
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    check("stream_done", 32'(no), 32'(n));
    cycles = cyc;
  endtask

  initial begin
    int cycles;
    u_if.in_valid = 0; u_if.in_data = '0; u_if.mode = 0; u_if.threshold = '0; u_if.out_ready = 1;
    u_if2.in_valid = 0; u_if2.in_data = '0; u_if2.mode = 0; u_if2.threshold = '0; u_if2.out_ready = 1;

    // reset state
    step(); step();
    check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_out_data", 32'(u_if.out_data), 32'd0);
    check("rst_beat_count", beat_count, 32'd0);
    nReset = 1'b1;
    step();
    check("rst_in_ready", 32'(u_if.in_ready), 32'd1);

    // single beat, 2-cycle latency
    u_if.in_valid = 1; u_if.in_data = 32'hFFFF_0000; u_if.mode = 0;
    step();
    u_if.in_valid = 0;
    check("lat_s1_not_valid", 32'(u_if.out_valid), 32'd0);
    step();
    check("lat_out_valid", 32'(u_if.out_valid), 32'd1);
    check("lat_out_data", 32'(u_if.out_data), 32'h0000_F900);
    step();
    check("lat_out_drop", 32'(u_if.out_valid), 32'd0);
    check("lat_beat_count", beat_count, 32'd1);

    // pure channels back-to-back
    set_beat(0, 32'hF800_07E0, 0, 8'h00, 16'h34B3);
    set_beat(1, 32'h001F_FFFF, 0, 8'h00, 16'h12F9);
    set_beat(2, 32'h0000_F800, 0, 8'h00, 16'h0034);
    run_stream(3, 100, 100, cycles);
    check("b2b_cycles", 32'(cycles), 32'd5);

    // threshold mode with per-beat config changes
    set_beat(0, 32'hFFFF_F800, 1, 8'h80, 16'hFF00);
    set_beat(1, 32'hFFFF_FFFF, 1, 8'hF9, 16'hFFFF);
    set_beat(2, 32'hFFFF_0000, 1, 8'hFA, 16'h0000);
    set_beat(3, 32'hFFFF_07E0, 0, 8'hFA, 16'hF9B3);
    set_beat(4, 32'h0000_001F, 1, 8'h00, 16'hFFFF);
    run_stream(5, 100, 100, cycles);
    check("thr_beat_count", beat_count, 32'd9);

    // reset with two beats in flight
    u_if.out_ready = 1; u_if.mode = 0;
    u_if.in_valid = 1; u_if.in_data = 32'hFFFF_FFFF;
    step();
    u_if.in_data = 32'hF800_F800;
    step();
    u_if.in_valid = 0;
    check("mid_pre_valid", 32'(u_if.out_valid), 32'd1);
    nReset = 0;
    #1;
    check("mid_rst_valid", 32'(u_if.out_valid), 32'd0);
    check("mid_rst_data", 32'(u_if.out_data), 32'd0);
    check("mid_rst_count", beat_count, 32'd0);
    step();
    nReset = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mid_no_stale%0d", i), 32'(u_if.out_valid), 32'd0);
    end
    check("mid_count_after", beat_count, 32'd0);

    // backpressure: 3 stalled cycles mid-stream
    set_beat(0, 32'h0000_F800, 0, 8'h00, 16'h0034);
    set_beat(1, 32'h07E0_001F, 0, 8'h00, 16'hB312);
    set_beat(2, 32'hFFFF_0000, 0, 8'h00, 16'hF900);
    set_beat(3, 32'hF800_F800, 0, 8'h00, 16'h3434);
    set_beat(4, 32'h001F_07E0, 0, 8'h00, 16'h12B3);
    run_stream(5, 3, 6, cycles);
    check("bp_cycles", 32'(cycles), 32'd10);
    check("bp_beat_count", beat_count, 32'd5);

    // count_clear coinciding with a transfer
    u_if.in_valid = 1; u_if.in_data = 32'h0000_0000;
    step();
    u_if.in_valid = 0;
    step();
    check("clr_out_valid", 32'(u_if.out_valid), 32'd1);
    count_clear = 1;
    step();
    count_clear = 0;
    check("clr_beat_count", beat_count, 32'd0);
    check("clr_out_drop", 32'(u_if.out_valid), 32'd0);

    // saturation on the WG=255 build
    u_if2.in_valid = 1; u_if2.in_data = 32'hFFFF_07E0;
    step();
    u_if2.in_valid = 0;
    step();
    check("sat_out_valid", 32'(u_if2.out_valid), 32'd1);
    check("sat_out_data", 32'(u_if2.out_data), 32'h0000_FFFB);
    step();
    check("sat_beat_count", beat_count2, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
